// File: rtl/md_unit.sv
//==============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers, busy/stall handshake, flush abort and a
//            divide-by-zero rule that leaves HI/LO untouched.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       Multiop,
    input  logic             mt_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDout
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_uns;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               start_mul;
    logic               start_div;
    logic               last_cycle;
    logic               idle;

    assign start_mul  = start && (Multiop[2:1] == 2'b00);
    assign start_div  = start && (Multiop[2:1] == 2'b01);
    assign idle       = (state == S_IDLE);
    assign last_cycle = !idle && (counter == CNT_W'(1));

    // ------------------------------------------------------------------
    // Result datapath, evaluated on the latched operands. Only sampled on
    // the final busy edge, so HI/LO never expose partial values.
    // ------------------------------------------------------------------
    logic               ext_a;
    logic               ext_b;
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] product;

    assign ext_a   = !op_uns && op_a[WIDTH-1];
    assign ext_b   = !op_uns && op_b[WIDTH-1];
    assign mul_a   = {{WIDTH{ext_a}}, op_a};
    assign mul_b   = {{WIDTH{ext_b}}, op_b};
    assign product = mul_a * mul_b;

    // Signed divide is done on magnitudes so MIN_INT / -1 wraps cleanly to
    // MIN_INT with a zero remainder; the remainder follows the dividend sign.
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               div_by_zero;

    assign a_mag       = ext_a ? (-op_a) : op_a;
    assign b_mag       = ext_b ? (-op_b) : op_b;
    assign div_by_zero = (op_b == '0);
    assign b_safe      = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign quo_mag     = a_mag / b_safe;
    assign rem_mag     = a_mag % b_safe;
    assign quotient    = (ext_a ^ ext_b) ? (-quo_mag) : quo_mag;
    assign remainder   = ext_a ? (-rem_mag) : rem_mag;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; flush overrides everything
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    state_next = S_MUL;
                end else if (start_div) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                busy = 1'b1;
                if (last_cycle) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Cycle counter and operand capture at launch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_uns  <= 1'b0;
        end else if (flush) begin
            counter <= '0;
        end else if (idle) begin
            if (start_mul || start_div) begin
                counter <= start_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                op_a    <= A;
                op_b    <= B;
                op_uns  <= Multiop[0];
            end
        end else begin
            counter <= counter - CNT_W'(1);
        end
    end

    // HI/LO update: result write on completion, or mthi/mtlo while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!flush) begin
            if (last_cycle) begin
                if (state == S_MUL) begin
                    hi_q <= product[2*WIDTH-1:WIDTH];
                    lo_q <= product[WIDTH-1:0];
                end else if (!div_by_zero) begin
                    hi_q <= remainder;
                    lo_q <= quotient;
                end
            end else if (idle && mt_en && !start) begin
                if (Multiop == 3'b100) begin
                    hi_q <= A;
                end else if (Multiop == 3'b101) begin
                    lo_q <= A;
                end
            end
        end
    end

    assign stall_req = busy | start;
    assign HI        = hi_q;
    assign LO        = lo_q;

    // Move-from read port on the current architectural registers
    always_comb begin
        MDout = '0;
        if (Multiop == 3'b111) begin
            MDout = hi_q;
        end else if (Multiop == 3'b110) begin
            MDout = lo_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
//==============================================================================
// Module   : tb_md_unit
// Purpose  : Scoreboard bench for md_unit; a 32-bit default instance and a
//            16-bit / 1-cycle mult / 17-cycle div instance.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_md_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    int compared   = 0;
    int mismatched = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  Multiop = 3'b000;
    logic        mt_en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    // 16-bit instance
    logic        s_rst_n = 1'b0;
    logic        s_start = 1'b0;
    logic [2:0]  s_Multiop = 3'b000;
    logic        s_mt_en = 1'b0;
    logic        s_flush = 1'b0;
    logic [15:0] s_A = '0;
    logic [15:0] s_B = '0;
    logic        s_busy;
    logic        s_stall_req;
    logic [15:0] s_HI;
    logic [15:0] s_LO;
    logic [15:0] s_MDout;

    exp_t q32[$];
    exp_t q16[$];

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset_n(rst_n), .start(start), .Multiop(Multiop),
        .mt_en(mt_en), .flush(flush), .A(A), .B(B), .busy(busy),
        .stall_req(stall_req), .HI(HI), .LO(LO), .MDout(MDout)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(17)) dut16 (
        .clk(clk), .reset_n(s_rst_n), .start(s_start), .Multiop(s_Multiop),
        .mt_en(s_mt_en), .flush(s_flush), .A(s_A), .B(s_B), .busy(s_busy),
        .stall_req(s_stall_req), .HI(s_HI), .LO(s_LO), .MDout(s_MDout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor, 32-bit instance: checks HI/LO and busy length
    int  cnt32  = 0;
    bit  prev32 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cnt32  = 0;
            prev32 = 1'b0;
        end else begin
            if (busy) cnt32++;
            if (prev32 && !busy) begin
                if (q32.size() == 0) begin
                    chk("q32_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("hi32", {32'd0, HI}, {32'd0, e.hi});
                    chk("lo32", {32'd0, LO}, {32'd0, e.lo});
                    chk("busy_len32", 64'(cnt32), 64'(e.len));
                end
                cnt32 = 0;
            end
            prev32 = busy;
        end
    end

    // Completion monitor, 16-bit instance
    int  cnt16  = 0;
    bit  prev16 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!s_rst_n) begin
            cnt16  = 0;
            prev16 = 1'b0;
        end else begin
            if (s_busy) cnt16++;
            if (prev16 && !s_busy) begin
                if (q16.size() == 0) begin
                    chk("q16_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q16.pop_front();
                    chk("hi16", {48'd0, s_HI}, {32'd0, e.hi});
                    chk("lo16", {48'd0, s_LO}, {32'd0, e.lo});
                    chk("busy_len16", 64'(cnt16), 64'(e.len));
                end
                cnt16 = 0;
            end
            prev16 = s_busy;
        end
    end

    task automatic wait_idle32();
        for (int i = 0; i < 40 && busy; i++) cyc();
        chk("timeout32", {63'd0, busy}, 64'd0);
        cyc();
    endtask

    task automatic wait_idle16();
        for (int i = 0; i < 40 && s_busy; i++) cyc();
        chk("timeout16", {63'd0, s_busy}, 64'd0);
        cyc();
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int len);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.len = len;
        q32.push_back(e);
        start = 1'b1; Multiop = op; A = a; B = b;
        #1;
        chk("stall_req_on_start", {63'd0, stall_req}, 64'd1);
        cyc();
        start = 1'b0;
        wait_idle32();
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_stall", {63'd0, stall_req}, 64'd0);
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
        cyc();

        // signed mult -2 * 3, then read LO/HI through MDout
        run32(3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        Multiop = 3'b110; #1;
        chk("mdout_lo", {32'd0, MDout}, {32'd0, 32'hFFFF_FFFA});
        Multiop = 3'b111; #1;
        chk("mdout_hi", {32'd0, MDout}, {32'd0, 32'hFFFF_FFFF});
        Multiop = 3'b010; #1;
        chk("mdout_other", {32'd0, MDout}, 64'd0);

        // divu and div
        run32(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        run32(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

        // mthi / mtlo preload
        mt_en = 1'b1; Multiop = 3'b100; A = 32'h1234;
        cyc();
        chk("mthi_hi", {32'd0, HI}, 64'h1234);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        Multiop = 3'b101; A = 32'h5678;
        cyc();
        mt_en = 1'b0;
        chk("mtlo_lo", {32'd0, LO}, 64'h5678);
        chk("mtlo_hi_kept", {32'd0, HI}, 64'h1234);

        // divide by zero leaves HI/LO untouched
        run32(3'b010, 32'd5, 32'd0, 32'h1234, 32'h5678, 10);

        // multu with an ignored second start at busy cycle 2
        e.hi = 32'hFFFF_FFFE; e.lo = 32'd1; e.len = 5;
        q32.push_back(e);
        start = 1'b1; Multiop = 3'b001; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; Multiop = 3'b000; A = 32'd3; B = 32'd5;
        cyc();
        start = 1'b0;
        wait_idle32();

        // div flushed at busy cycle 4
        e.hi = 32'hFFFF_FFFE; e.lo = 32'd1; e.len = 4;
        q32.push_back(e);
        start = 1'b1; Multiop = 3'b010; A = 32'd100; B = 32'd3;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        wait_idle32();

        // mtlo during busy is ignored (div by zero keeps HI/LO)
        e.hi = 32'hFFFF_FFFE; e.lo = 32'd1; e.len = 10;
        q32.push_back(e);
        start = 1'b1; Multiop = 3'b010; A = 32'd9; B = 32'd0;
        cyc();
        start = 1'b0; mt_en = 1'b1; Multiop = 3'b101; A = 32'hDEAD;
        cyc();
        mt_en = 1'b0;
        chk("mt_busy_lo", {32'd0, LO}, 64'd1);
        wait_idle32();

        // MIN_INT / -1 and positive / negative
        run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        run32(3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);

        // 16-bit instance: signed 0x8000 * 0x8000 in one busy cycle
        e.hi = 32'h4000; e.lo = 32'd0; e.len = 1;
        q16.push_back(e);
        s_start = 1'b1; s_Multiop = 3'b000; s_A = 16'h8000; s_B = 16'h8000;
        cyc();
        s_start = 1'b0;
        wait_idle16();

        // asynchronous reset in the middle of a divide
        s_start = 1'b1; s_Multiop = 3'b011; s_A = 16'd100; s_B = 16'd7;
        cyc();
        s_start = 1'b0; s_Multiop = 3'b111;
        repeat (3) cyc();
        chk("s_busy_mid", {63'd0, s_busy}, 64'd1);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("s_rst_hi", {48'd0, s_HI}, 64'd0);
        chk("s_rst_lo", {48'd0, s_LO}, 64'd0);
        chk("s_rst_busy", {63'd0, s_busy}, 64'd0);
        chk("s_rst_mdout", {48'd0, s_MDout}, 64'd0);
        cyc();
        s_rst_n = 1'b1;
        cyc();

        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q16_empty", 64'(q16.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
